// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: in-order FIFO of stores drained to data memory,
// with byte-granular forwarding of queued store data into loads.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_wdata,
    input  logic [3:0]       st_be,
    input  logic [31:0]      st_pc,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      dm_rdata,
    output logic [31:0]      ld_data,
    output logic             ld_hit,
    input  logic             dm_ready,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_pc,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [29:0]      ent_widx [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [31:0]      ent_pc   [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] scan_idx;
    logic [3:0]       lane_hit;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full;
    assign push     = st_valid && st_ready;
    assign dm_we    = !empty;
    assign pop      = dm_we && dm_ready;

    assign dm_addr  = {ent_widx[rd_ptr], 2'b00};
    assign dm_wdata = ent_data[rd_ptr];
    assign dm_be    = ent_be[rd_ptr];
    assign dm_pc    = ent_pc[rd_ptr];

    // Pointer wrap relies on DEPTH being exactly 2**PTR_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                ent_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                ent_valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload is qualified by ent_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_widx[wr_ptr] <= st_addr[31:2];
            ent_data[wr_ptr] <= st_wdata;
            ent_be[wr_ptr]   <= st_be;
            ent_pc[wr_ptr]   <= st_pc;
        end
    end

    // Scan oldest to youngest so the youngest matching store owns each lane.
    always_comb begin
        ld_data  = dm_rdata;
        lane_hit = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PTR_W'(k);
            if (ent_valid[scan_idx] && (ent_widx[scan_idx] == ld_addr[31:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (ent_be[scan_idx][i]) begin
                        ld_data[8*i +: 8] = ent_data[scan_idx][8*i +: 8];
                        lane_hit[i]       = 1'b1;
                    end
                end
            end
        end
        ld_hit = |lane_hit;
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer (DEPTH=4).
module tb_dm_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] st_pc;
    logic [31:0] ld_addr;
    logic [31:0] dm_rdata;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        dm_ready;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_be(st_be), .st_pc(st_pc),
        .ld_addr(ld_addr), .dm_rdata(dm_rdata), .ld_data(ld_data), .ld_hit(ld_hit),
        .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_pc(dm_pc), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic [31:0] p);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_be    = b;
        st_pc    = p;
        step();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dm_rdata = 32'h5566_7788;
        ld_addr = 32'h0;
        #12;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 || dm_we !== 1'b0 ||
            ld_hit !== 1'b0 || ld_data !== 32'h5566_7788) begin
            errors++;
            $display("[TB] FAIL reset_hold: count=%0d empty=%b st_ready=%b dm_we=%b ld_hit=%b ld_data=%h, expected 0 1 1 0 0 55667788",
                     count, empty, st_ready, dm_we, ld_hit, ld_data);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        push_store(32'h0000_0040, $urandom, 4'hF, 32'h100);
        push_store(32'h0000_0040, $urandom, 4'hF, 32'h104);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL reset_prefill: count=%0d expected 2", count);
        end
        ld_addr = 32'h0000_0040;
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 || dm_we !== 1'b0 || ld_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: count=%0d empty=%b st_ready=%b dm_we=%b ld_hit=%b, expected 0 1 1 0 0",
                     count, empty, st_ready, dm_we, ld_hit);
        end
        step();
    endtask

    task automatic test_single_store();
        dm_ready = 1'b1;
        st_valid = 1'b1;
        st_addr  = 32'h0000_0010;
        st_wdata = 32'hDEAD_BEEF;
        st_be    = 4'hF;
        st_pc    = 32'h0000_2000;
        ld_addr  = 32'h0000_0010;
        #1;
        checks++;
        if (dm_we !== 1'b0 || ld_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_no_bypass: dm_we=%b ld_hit=%b expected 0 0", dm_we, ld_hit);
        end
        step();
        st_valid = 1'b0;
        checks++;
        if (dm_we !== 1'b1 || dm_addr !== 32'h10 || dm_wdata !== 32'hDEAD_BEEF ||
            dm_be !== 4'hF || dm_pc !== 32'h2000) begin
            errors++;
            $display("[TB] FAIL single_drain: we=%b addr=%h data=%h be=%h pc=%h expected 1 00000010 deadbeef f 00002000",
                     dm_we, dm_addr, dm_wdata, dm_be, dm_pc);
        end
        step();
        checks++;
        if (empty !== 1'b1 || dm_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_empty: empty=%b dm_we=%b expected 1 0", empty, dm_we);
        end
    endtask

    task automatic test_fill_backpressure();
        dm_ready = 1'b0;
        for (int j = 0; j < 4; j++)
            push_store(32'h0000_0100 + 32'(j*4), 32'hC0DE_0000 + 32'(j), 4'hF, 32'h3000 + 32'(j*4));
        checks++;
        if (count !== 3'd4 || st_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_full: count=%0d st_ready=%b expected 4 0", count, st_ready);
        end
        st_valid = 1'b1;
        st_addr  = 32'h0000_0200;
        st_wdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (st_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_fifth_flag: st_ready=%b expected 0 with st_valid", st_ready);
        end
        dm_ready = 1'b1;
        step();
        st_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || st_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fill_first_pop: count=%0d st_ready=%b expected 3 1", count, st_ready);
        end
        for (int j = 1; j < 4; j++) begin
            checks++;
            if (dm_we !== 1'b1 || dm_addr !== 32'h100 + 32'(j*4) || dm_wdata !== 32'hC0DE_0000 + 32'(j)) begin
                errors++;
                $display("[TB] FAIL fill_order_%0d: we=%b addr=%h data=%h expected 1 %h %h",
                         j, dm_we, dm_addr, dm_wdata, 32'h100 + 32'(j*4), 32'hC0DE_0000 + 32'(j));
            end
            step();
        end
        checks++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL fill_drained: empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_forwarding();
        dm_ready = 1'b0;
        push_store(32'h20, 32'h0000_00AA, 4'b0001, 32'h400);
        push_store(32'h20, 32'h0000_BB00, 4'b0010, 32'h404);
        push_store(32'h20, 32'h0000_00CC, 4'b0001, 32'h408);
        dm_rdata = 32'h1122_3344;
        ld_addr  = 32'h20;
        #1;
        checks++;
        if (ld_data !== 32'h1122_BBCC || ld_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fwd_merge: ld_data=%h ld_hit=%b expected 1122bbcc 1", ld_data, ld_hit);
        end
        ld_addr = 32'h23;
        #1;
        checks++;
        if (ld_data !== 32'h1122_BBCC || ld_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fwd_low_bits: ld_data=%h ld_hit=%b expected 1122bbcc 1", ld_data, ld_hit);
        end
        ld_addr = 32'h24;
        #1;
        checks++;
        if (ld_data !== 32'h1122_3344 || ld_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwd_miss: ld_data=%h ld_hit=%b expected 11223344 0", ld_data, ld_hit);
        end
        ld_addr  = 32'h20;
        dm_ready = 1'b1;
        step();
        step();
        checks++;
        if (ld_data !== 32'h1122_33CC || ld_hit !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL fwd_after_pops: ld_data=%h ld_hit=%b count=%0d expected 112233cc 1 1",
                     ld_data, ld_hit, count);
        end
        step();
    endtask

    task automatic test_zero_be();
        dm_ready = 1'b1;
        dm_rdata = 32'hAABB_CCDD;
        ld_addr  = 32'h30;
        push_store(32'h30, 32'hFFFF_FFFF, 4'b0000, 32'h500);
        checks++;
        if (dm_we !== 1'b1 || dm_be !== 4'b0000 || dm_addr !== 32'h30 || ld_hit !== 1'b0 || ld_data !== 32'hAABB_CCDD) begin
            errors++;
            $display("[TB] FAIL zero_be: we=%b be=%b addr=%h ld_hit=%b ld_data=%h expected 1 0000 00000030 0 aabbccdd",
                     dm_we, dm_be, dm_addr, ld_hit, ld_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        int sent;
        int cyc;
        logic pushing;
        logic popping;
        sent = 0;
        cyc  = 0;
        while (cyc < 200 && (sent < 10 || q.size() > 0)) begin
            dm_ready = ((cyc % 2) == 1);
            st_valid = (sent < 10) && (q.size() < 4);
            st_addr  = 32'h0000_0800 + 32'(sent*4);
            st_wdata = 32'h5A5A_0000 + 32'(sent);
            st_be    = 4'hF;
            st_pc    = 32'h6000 + 32'(sent*4);
            #1;
            checks++;
            if (count !== 3'(q.size()) || st_ready !== (q.size() < 4) || dm_we !== (q.size() > 0)) begin
                errors++;
                $display("[TB] FAIL stream_state_c%0d: count=%0d st_ready=%b dm_we=%b expected %0d %b %b",
                         cyc, count, st_ready, dm_we, q.size(), q.size() < 4, q.size() > 0);
            end
            if (q.size() > 0) begin
                checks++;
                if (dm_wdata !== q[0] || dm_addr !== 32'h800 + {q[0][29:0], 2'b00} - 32'h5A5A_0000 * 4) begin
                    errors++;
                    $display("[TB] FAIL stream_head_c%0d: data=%h addr=%h expected data %h", cyc, dm_wdata, dm_addr, q[0]);
                end
            end
            pushing = st_valid && (q.size() < 4);
            popping = dm_ready && (q.size() > 0);
            @(posedge clk);
            if (popping) void'(q.pop_front());
            if (pushing) begin
                q.push_back(32'h5A5A_0000 + 32'(sent));
                sent++;
            end
            #1;
            st_valid = 1'b0;
            cyc++;
        end
        checks++;
        if (sent != 10 || q.size() != 0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_complete: sent=%0d left=%0d empty=%b expected 10 0 1", sent, q.size(), empty);
        end
    endtask

    task automatic test_reset_mid_drain();
        dm_ready = 1'b0;
        push_store(32'h40, 32'h1111_1111, 4'hF, 32'h700);
        push_store(32'h44, 32'h2222_2222, 4'hF, 32'h704);
        push_store(32'h48, 32'h3333_3333, 4'hF, 32'h708);
        checks++;
        if (count !== 3'd3 || dm_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL middrain_setup: count=%0d dm_we=%b expected 3 1", count, dm_we);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dm_we !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL middrain_async: dm_we=%b count=%0d empty=%b expected 0 0 1", dm_we, count, empty);
        end
        dm_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            checks++;
            if (dm_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL middrain_after_%0d: dm_we=%b expected 0", j, dm_we);
            end
        end
    endtask

    initial begin
        st_valid = 1'b0;
        st_addr  = '0;
        st_wdata = '0;
        st_be    = '0;
        st_pc    = '0;
        dm_ready = 1'b0;
        test_reset();
        test_single_store();
        test_fill_backpressure();
        test_forwarding();
        test_zero_be();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write buffer between the datapath's store path and the data memory.
- Stores are accepted in one cycle and queued in a small in-order FIFO, then drained to the data memory one entry per cycle when it signals ready.
- Loads see queued stores through byte-granular forwarding, merged over the memory read data, so program order is preserved.
- Lets the core retire stores without waiting on memory write occupancy.

Parameters:
- DEPTH, 4, number of queued stores; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); pointer width. Count width is PTR_W+1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- st_valid  input  1  store request this cycle.
- st_ready  output  1  buffer can accept a store; equals not full.
- st_addr  input  32  store byte address; bits [1:0] ignored, word index = st_addr[31:2].
- st_wdata  input  32  store data, already lane-aligned.
- st_be  input  4  byte enables; be[i] covers bits [8i+7:8i].
- st_pc  input  32  PC of the store, carried for the write log.
- ld_addr  input  32  load address for forwarding lookup.
- dm_rdata  input  32  word read from data memory at ld_addr.
- ld_data  output  32  dm_rdata with queued store bytes merged in.
- ld_hit  output  1  at least one byte of ld_data came from the buffer.
- dm_ready  input  1  data memory accepts a write this cycle.
- dm_we  output  1  head entry presented to memory.
- dm_addr  output  32  {head word index, 2'b00}.
- dm_wdata  output  32  head data.
- dm_be  output  4  head byte enables.
- dm_pc  output  32  head PC.
- empty  output  1  no entries queued; core uses it to fence (syscall, halt).
- count  output  PTR_W+1  number of valid entries.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset, asynchronous on reset=0:
  - wr_ptr, rd_ptr and count reset to 0.
  - All entry valid bits are cleared; entry data need not be cleared.
  - Outputs while in reset: st_ready=1, empty=1, dm_we=0, ld_hit=0, ld_data=dm_rdata.
  - A reset asserted mid-drain discards every queued entry with no further dm_we.
- Push: on a rising edge with st_valid && st_ready:
  - Write entry[wr_ptr] = {st_addr[31:2], st_wdata, st_be, st_pc}.
  - wr_ptr wraps modulo DEPTH.
  - st_valid with st_ready=0 is dropped; the core must stall. The bench flags it as an error.
- Store with st_be=4'b0000: accepted and queued; drained with dm_be=0 (no-op write at memory).
- Pop / drain:
  - dm_we = !empty. dm_addr, dm_wdata, dm_be and dm_pc come combinationally from entry[rd_ptr].
  - On a rising edge with dm_we && dm_ready, the head retires and rd_ptr wraps modulo DEPTH.
  - dm_ready=0 holds all dm_* outputs stable.
- Latency: a store pushed at edge N appears on dm_we after edge N when the buffer was empty; it retires at the first later edge with dm_ready=1.
- No same-cycle bypass:
  - A store cannot appear on dm_* in the cycle it is presented.
  - Push and pop in the same edge: count unchanged, both pointers advance.
  - When full, st_ready=0 even if a pop occurs that edge; the slot frees on the next cycle.
- count increments on push-only, decrements on pop-only, otherwise holds. It never exceeds DEPTH and never underflows.
- Forwarding (combinational):
  - For each byte lane i, scan valid entries from oldest to youngest, starting at rd_ptr.
  - Lane i takes the data of the youngest entry whose word index matches ld_addr[31:2] and whose be[i]=1; otherwise it takes dm_rdata lane i.
  - ld_hit = OR over all lanes of "taken from buffer".
  - The head entry being popped this cycle still forwards; memory updates at the same edge.
  - A store presented this cycle is not forwarded.
- Ordering: drain is strictly FIFO. No coalescing and no reordering.

Test Plan:
- Reset behaviour: hold reset=0 after random pushes, release -> count=0, empty=1, st_ready=1, dm_we=0, ld_hit=0.
- Single store: push addr 0x0000_0010, data 0xDEADBEEF, be 4'b1111, dm_ready=1 -> the next cycle shows dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF. After that edge empty=1.
- Fill/back-pressure, DEPTH=4, dm_ready=0:
  - Push 4 stores -> count=4, st_ready=0, a 5th st_valid is flagged.
  - Raise dm_ready -> the 4 stores drain in order on 4 consecutive edges and st_ready returns 1 one cycle after the first pop.
- Byte forwarding, with dm_ready=0:
  - Push 0x20 data 0x000000AA be 0001, then 0x20 data 0x0000BB00 be 0010, then 0x20 data 0x000000CC be 0001.
  - Load 0x20 with dm_rdata=0x11223344 -> ld_data=0x1122BBCC, ld_hit=1.
  - Load 0x24 -> ld_data=dm_rdata, ld_hit=0.
- Wrap-around: with dm_ready toggling 1/0 each cycle, stream 10 stores through -> pointers wrap, the dm_* sequence equals the push order, and count stays within 0..4.
- Async reset mid-drain: with 3 stores queued, assert reset between clock edges -> dm_we drops to 0 immediately and no queued store reaches memory after release.
